// File: rtl/sync_event_collector.sv
// sync_event_collector
// Destination-side receiver for toggle events crossing into the CLK domain.
// Each channel synchronises an asynchronous toggle line through a flop chain
// and turns every transition into a one-cycle pulse. Pulses are counted per
// channel so that bursts queue up. Pending events are offered one at a time
// on a valid/ready port, and channels are served round-robin.
//
// Ports:
//   CLK          destination clock
//   RST          asynchronous active-high reset
//   sToggle      per-channel toggle lines, asynchronous to CLK
//   dPulse       per-channel one-cycle event pulse (combinational)
//   evValid      registered: an event is offered
//   evChan       registered: channel of the offered event
//   evReady      consumer accepts the offered event
//   overflow     sticky per-channel flag: event dropped at a saturated counter
//   clrOverflow  synchronous clear for the matching overflow bits
module sync_event_collector #(
  parameter int CHANNELS = 4,
  parameter int STAGES   = 2,
  parameter int CNTW     = 3,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CHANNELS-1:0] sToggle,
  output logic [CHANNELS-1:0] dPulse,
  output logic                evValid,
  output logic [CW-1:0]       evChan,
  input  logic                evReady,
  output logic [CHANNELS-1:0] overflow,
  input  logic [CHANNELS-1:0] clrOverflow
);

  typedef enum logic {ST_IDLE, ST_OFFER} state_t;

  localparam logic [CNTW-1:0] CNT_MAX   = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
  localparam logic [CW-1:0]   LAST_CHAN = CW'(CHANNELS - 1);
  localparam logic [CW:0]     NUM_CHAN  = (CW + 1)'(CHANNELS);

  logic [CHANNELS-1:0] r_sync [STAGES];
  logic [CHANNELS-1:0] r_edge;
  logic [CNTW-1:0]     r_cnt [CHANNELS];
  logic [CW-1:0]       r_rr;
  state_t              r_state;

  state_t              w_stateNext;
  logic                w_accept;
  logic [CHANNELS-1:0] w_dec;
  logic [CHANNELS-1:0] w_avail;
  logic [CW-1:0]       w_chanPlus1;
  logic [CW-1:0]       w_base;
  logic                w_found;
  logic [CW-1:0]       w_foundChan;
  logic                w_validNext;
  logic [CW-1:0]       w_chanNext;
  logic [CW-1:0]       w_rrNext;

  // Synchroniser chain followed by the edge flop that remembers the last
  // synchronised level, so a level change shows up as a single pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < STAGES; s++) r_sync[s] <= '0;
      r_edge <= '0;
    end else begin
      r_sync[0] <= sToggle;
      for (int s = 1; s < STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_edge <= r_sync[STAGES-1];
    end
  end

  assign dPulse   = r_sync[STAGES-1] ^ r_edge;
  assign w_accept = evValid && evReady;

  // A channel is offerable if it still has a pending event once this cycle's
  // accept is taken off. This cycle's increments are deliberately ignored.
  always_comb begin
    w_dec   = '0;
    w_avail = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_dec[i]   = w_accept && (evChan == CW'(i));
      w_avail[i] = (r_cnt[i] != '0) && !(w_dec[i] && (r_cnt[i] == CNT_ONE));
    end
  end

  // Pending counters and sticky overflow. Increment and decrement in the
  // same cycle cancel out, even at saturation. Setting overflow wins
  // over clearing it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < CHANNELS; i++) r_cnt[i] <= '0;
      overflow <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (dPulse[i] && !w_dec[i]) begin
          if (r_cnt[i] != CNT_MAX) r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end else if (!dPulse[i] && w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] - CNT_ONE;
        end
        if (dPulse[i] && !w_dec[i] && (r_cnt[i] == CNT_MAX)) overflow[i] <= 1'b1;
        else if (clrOverflow[i])                              overflow[i] <= 1'b0;
      end
    end
  end

  // After an accept, the search starts just past the channel just served.
  // This is what makes the service order round-robin.
  assign w_chanPlus1 = (evChan == LAST_CHAN) ? '0 : evChan + CW'(1);
  assign w_base      = w_accept ? w_chanPlus1 : r_rr;

  // Wrapping priority search. The loop scans from the far end so that the
  // last hit written is the nearest one to w_base.
  always_comb begin
    logic [CW:0] idx;
    idx         = '0;
    w_found     = 1'b0;
    w_foundChan = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = {1'b0, w_base} + (CW + 1)'(k);
      if (idx >= NUM_CHAN) idx = idx - NUM_CHAN;
      if (w_avail[idx[CW-1:0]]) begin
        w_found     = 1'b1;
        w_foundChan = idx[CW-1:0];
      end
    end
  end

  // Output FSM: state register together with the registered offer outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      evValid <= 1'b0;
      evChan  <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_stateNext;
      evValid <= w_validNext;
      evChan  <= w_chanNext;
      r_rr    <= w_rrNext;
    end
  end

  // Output FSM: next state.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:  if (w_found) w_stateNext = ST_OFFER;
      ST_OFFER: if (w_accept && !w_found) w_stateNext = ST_IDLE;
      default:  w_stateNext = ST_IDLE;
    endcase
  end

  // Output FSM: next offer. An offer that is not accepted is held unchanged.
  always_comb begin
    w_validNext = evValid;
    w_chanNext  = evChan;
    w_rrNext    = r_rr;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_validNext = 1'b1;
          w_chanNext  = w_foundChan;
        end
      end
      ST_OFFER: begin
        if (w_accept) begin
          w_rrNext    = w_chanPlus1;
          w_validNext = w_found;
          if (w_found) w_chanNext = w_foundChan;
        end
      end
      default: w_validNext = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sync_event_collector.sv
// Testbench for sync_event_collector (CHANNELS=4, STAGES=2, CNTW=3).
// A per-cycle vector table covers a single event and a round-robin burst.
// Hand-written sequences cover queueing, saturation, fairness, random
// back-pressure and asynchronous reset.
module tb_sync_event_collector;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] sToggle;
  logic [3:0] dPulse;
  logic       evValid;
  logic [1:0] evChan;
  logic       evReady;
  logic [3:0] overflow;
  logic [3:0] clrOverflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] tog;
    logic       rdy;
    logic [3:0] clr;
    logic [3:0] expPulse;
    logic       expValid;
    logic [1:0] expChan;
    logic [3:0] expOvf;
  } vec_t;

  vec_t vecs [17];

  sync_event_collector #(.CHANNELS(4), .STAGES(2), .CNTW(3)) dut (
    .CLK(CLK), .RST(RST), .sToggle(sToggle), .dPulse(dPulse),
    .evValid(evValid), .evChan(evChan), .evReady(evReady),
    .overflow(overflow), .clrOverflow(clrOverflow)
  );

  always #5 CLK = ~CLK;

  // Inputs change on the falling edge; outputs are sampled on the falling
  // edge after the rising edge.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic applyStimulus(input logic [3:0] tog, input logic rdy, input logic [3:0] clr);
    sToggle     = tog;
    evReady     = rdy;
    clrOverflow = clr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic doReset();
    applyStimulus(4'b0000, 1'b0, 4'b0000);
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic waitValid(input string name, input int budget);
    for (int n = 0; n < budget && !evValid; n++) tick();
    checkOutput(name, 32'(evValid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] tog;
    int         acc;
    int         evExp;
    int         got [8];
    int         expOrder [5];
    logic       prevHold;
    logic [1:0] prevChan;

    // Columns: sToggle, evReady, clrOverflow | expected dPulse, evValid, evChan, overflow
    vecs[0]  = '{4'b0100, 1'b0, 4'b0, 4'b0000, 1'b0, 2'd0, 4'b0};
    vecs[1]  = '{4'b0100, 1'b0, 4'b0, 4'b0100, 1'b0, 2'd0, 4'b0};
    vecs[2]  = '{4'b0100, 1'b0, 4'b0, 4'b0000, 1'b0, 2'd0, 4'b0};
    vecs[3]  = '{4'b0100, 1'b0, 4'b0, 4'b0000, 1'b1, 2'd2, 4'b0};
    vecs[4]  = '{4'b0100, 1'b0, 4'b0, 4'b0000, 1'b1, 2'd2, 4'b0};
    vecs[5]  = '{4'b0100, 1'b1, 4'b0, 4'b0000, 1'b0, 2'd0, 4'b0};
    vecs[6]  = '{4'b0100, 1'b1, 4'b0, 4'b0000, 1'b0, 2'd0, 4'b0};
    vecs[7]  = '{4'b0100, 1'b1, 4'b0, 4'b0000, 1'b0, 2'd0, 4'b0};
    vecs[8]  = '{4'b1011, 1'b0, 4'b0, 4'b0000, 1'b0, 2'd0, 4'b0};
    vecs[9]  = '{4'b1011, 1'b0, 4'b0, 4'b1111, 1'b0, 2'd0, 4'b0};
    vecs[10] = '{4'b1011, 1'b0, 4'b0, 4'b0000, 1'b0, 2'd0, 4'b0};
    vecs[11] = '{4'b1011, 1'b0, 4'b0, 4'b0000, 1'b1, 2'd3, 4'b0};
    vecs[12] = '{4'b1011, 1'b1, 4'b0, 4'b0000, 1'b1, 2'd0, 4'b0};
    vecs[13] = '{4'b1011, 1'b1, 4'b0, 4'b0000, 1'b1, 2'd1, 4'b0};
    vecs[14] = '{4'b1011, 1'b1, 4'b0, 4'b0000, 1'b1, 2'd2, 4'b0};
    vecs[15] = '{4'b1011, 1'b1, 4'b0, 4'b0000, 1'b0, 2'd0, 4'b0};
    vecs[16] = '{4'b1011, 1'b0, 4'b0, 4'b0000, 1'b0, 2'd0, 4'b0};

    RST = 1'b1;
    applyStimulus(4'b0000, 1'b0, 4'b0000);
    @(negedge CLK);
    doReset();
    checkOutput("reset_valid", 32'(evValid), 32'd0);
    checkOutput("reset_chan", 32'(evChan), 32'd0);
    checkOutput("reset_ovf", 32'(overflow), 32'd0);
    checkOutput("reset_pulse", 32'(dPulse), 32'd0);

    // Single event on channel 2, then a four-channel round-robin burst.
    for (int c = 0; c < 17; c++) begin
      applyStimulus(vecs[c].tog, vecs[c].rdy, vecs[c].clr);
      tick();
      checkOutput($sformatf("vec%0d_pulse", c), 32'(dPulse), 32'(vecs[c].expPulse));
      checkOutput($sformatf("vec%0d_valid", c), 32'(evValid), 32'(vecs[c].expValid));
      if (vecs[c].expValid)
        checkOutput($sformatf("vec%0d_chan", c), 32'(evChan), 32'(vecs[c].expChan));
      checkOutput($sformatf("vec%0d_ovf", c), 32'(overflow), 32'(vecs[c].expOvf));
    end

    // Six queued events on channel 1, drained back to back.
    doReset();
    tog = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      tog[1] = ~tog[1];
      applyStimulus(tog, 1'b0, 4'b0000);
      repeat (4) tick();
    end
    checkOutput("A_ovf", 32'(overflow), 32'd0);
    checkOutput("A_offerChan", 32'(evChan), 32'd1);
    evReady = 1'b1;
    acc = 0;
    for (int n = 0; n < 20 && evValid; n++) begin
      checkOutput("A_chan", 32'(evChan), 32'd1);
      acc++;
      tick();
    end
    checkOutput("A_accepts", 32'(acc), 32'd6);
    checkOutput("A_validLow", 32'(evValid), 32'd0);

    // Eight events on channel 0: the eighth hits a saturated counter.
    doReset();
    tog = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      tog[0] = ~tog[0];
      applyStimulus(tog, 1'b0, 4'b0000);
      repeat (4) tick();
      if (k == 6) checkOutput("B_ovfBeforeSat", 32'(overflow), 32'd0);
    end
    checkOutput("B_ovfSet", 32'(overflow), 32'b0001);
    repeat (3) tick();
    checkOutput("B_ovfSticky", 32'(overflow), 32'b0001);
    applyStimulus(tog, 1'b0, 4'b0001);
    tick();
    checkOutput("B_ovfCleared", 32'(overflow), 32'd0);
    applyStimulus(tog, 1'b1, 4'b0000);
    acc = 0;
    for (int n = 0; n < 20 && evValid; n++) begin
      acc++;
      tick();
    end
    checkOutput("B_accepts", 32'(acc), 32'd7);

    // Fairness: 0,1,2,3, then a new channel-0 event arriving mid-burst.
    doReset();
    tog = 4'b1111;
    applyStimulus(tog, 1'b0, 4'b0000);
    waitValid("C_firstOffer", 10);
    checkOutput("C_firstChan", 32'(evChan), 32'd0);
    tog[0] = 1'b0;
    applyStimulus(tog, 1'b1, 4'b0000);
    acc = 0;
    for (int n = 0; n < 12; n++) begin
      if (evValid && evReady && acc < 8) begin
        got[acc] = int'(evChan);
        acc++;
      end
      tick();
    end
    expOrder = '{0, 1, 2, 3, 0};
    checkOutput("C_count", 32'(acc), 32'd5);
    for (int i = 0; i < 5 && i < acc; i++)
      checkOutput($sformatf("C_order%0d", i), 32'(got[i]), 32'(expOrder[i]));

    // Random back-pressure while events keep arriving.
    doReset();
    tog = 4'b0000;
    evExp = 0;
    acc = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc % 4 == 0) begin
        tog[(cyc / 4) % 4] = ~tog[(cyc / 4) % 4];
        evExp++;
      end
      applyStimulus(tog, ($urandom_range(0, 2) != 0), 4'b0000);
      if (evValid && evReady) acc++;
      prevHold = evValid && !evReady;
      prevChan = evChan;
      tick();
      if (prevHold) begin
        checkOutput("D_holdValid", 32'(evValid), 32'd1);
        checkOutput("D_holdChan", 32'(evChan), 32'(prevChan));
      end
    end
    evReady = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (evValid) acc++;
      tick();
    end
    checkOutput("D_accepts", 32'(acc), 32'(evExp));
    checkOutput("D_ovf", 32'(overflow), 32'd0);

    // Asynchronous reset during an offer with counts pending.
    doReset();
    tog = 4'b1110;
    applyStimulus(tog, 1'b0, 4'b0000);
    waitValid("E_offer", 10);
    checkOutput("E_offerChan", 32'(evChan), 32'd1);
    #2;
    RST = 1'b1;
    applyStimulus(4'b0000, 1'b0, 4'b0000);
    #1;
    checkOutput("E_rstValid", 32'(evValid), 32'd0);
    checkOutput("E_rstChan", 32'(evChan), 32'd0);
    checkOutput("E_rstOvf", 32'(overflow), 32'd0);
    checkOutput("E_rstPulse", 32'(dPulse), 32'd0);
    @(negedge CLK);
    tick();
    RST = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      checkOutput("E_quietValid", 32'(evValid), 32'd0);
      checkOutput("E_quietPulse", 32'(dPulse), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_event_collector.md
# sync_event_collector

Multi-channel toggle-event receiver for the destination side of a clock-domain crossing. Each channel takes an asynchronous toggle line from a foreign domain, synchronises it through a parametrised flop chain and converts each toggle into a one-cycle pulse. The block also counts events per channel, so closely spaced events are queued instead of lost, and presents them one at a time on a valid/ready port with round-robin fairness. It is the parametrised successor to the single-channel pulse synchroniser.

## Interface

Parameters:
- CHANNELS, default 4: number of independent toggle channels, 1..16.
- STAGES, default 2: synchroniser depth in flops, at least 2.
- CNTW, default 3: width of each per-channel pending counter, at least 1.

Ports:
- CLK  input  1: destination clock; the only clock in the block.
- RST  input  1: asynchronous, active-high reset.
- sToggle  input  CHANNELS: toggle lines, asynchronous to CLK. Each transition of bit i is one event on channel i.
- dPulse  output  CHANNELS: one-cycle pulse per detected event. Combinational from the last sync stage and the edge flop.
- evValid  output  1: registered; an event is offered.
- evChan  output  max(1,clog2(CHANNELS)): registered; channel of the offered event.
- evReady  input  1: consumer accepts the offered event.
- overflow  output  CHANNELS: sticky per-channel flag; an event was dropped because the channel's counter was saturated.
- clrOverflow  input  CHANNELS: synchronous clear for the matching overflow bits.

## Operation

- Reset value of every flop is 0: sync chains, edge flops, counters, overflow, round-robin pointer, FSM (IDLE), evValid, evChan.
- Any sToggle bit high at reset release produces one event on that channel; this is defined behaviour.

Per-channel synchroniser:
- sToggle[i] passes through STAGES flops, then one edge flop.
- dPulse[i] = last stage XOR edge flop.

Per-channel pending counter cnt[i], updated each cycle as follows:
- inc = dPulse[i]
- dec = accept on channel i, where accept = evValid && evReady && evChan == i
- inc only: if cnt < 2^CNTW-1, cnt+1; otherwise hold and set overflow[i].
- dec only: cnt-1.
- inc and dec together: hold, including at saturation; no overflow in that case.
- Overflow set takes priority over clrOverflow in the same cycle.

Output FSM:
- IDLE:
  - If any cnt is nonzero, load evChan with the first nonzero channel searching from pointer rr upward (wrapping), set evValid, go to OFFER.
  - Otherwise stay in IDLE.
- OFFER, evReady low:
  - Hold evValid and evChan stable.
  - The offer is never withdrawn or changed.
- OFFER, evReady high (accept):
  - rr becomes evChan+1, wrapping to 0 after CHANNELS-1.
  - Reselect using counts after this cycle's decrement but excluding this cycle's increments, searching from the new rr.
  - If a channel is found, load it and stay in OFFER. This gives back-to-back transfers.
  - Otherwise clear evValid and go to IDLE.
- The search uses registered counts only. The event counted at a given edge is offerable from the next edge.

## Timing

- An sToggle edge captured by sync stage 1 at edge E0:
  - dPulse is high in the cycle after edge E0+STAGES-1.
  - cnt increments at edge E0+STAGES.
  - evValid rises at edge E0+STAGES+1 at the earliest, from IDLE.
- Throughput is one event per cycle while evReady is held high and events are pending.
- Toggles on one channel closer than one CLK period may merge or be missed. This is inherent to the protocol, and the block does not detect it.
- Assertion of RST mid-offer clears evValid asynchronously and discards all pending counts.

## Test plan

- CHANNELS=4, STAGES=2: reset, then toggle sToggle[2] once. Required: one dPulse[2] pulse three edges later; evValid=1 with evChan=2 one edge after the count; evReady=1 leaves all cnt at 0.
- STAGES=3, evReady=0: toggle channel 1 six times, 4 cycles apart. With CNTW=3 the count reaches 6; overflow[1] stays 0. Then evReady=1: exactly six consecutive accepts with evChan=1, then evValid=0.
- CNTW=2: eight toggles on channel 0 with evReady=0. Required: cnt saturates at 3; overflow[0]=1 and stays set; clrOverflow[0] clears it.
- One event pending on each of channels 0..3, evReady=1 from IDLE. Required: accept order 0,1,2,3. A new event on channel 0 arriving during the burst is served after channel 3.
- evReady toggled randomly while events arrive. Required: evChan never changes while evValid=1 and evReady=0; accepts equal the count of dPulse pulses minus dropped events.
- RST asserted while evValid=1 and counts are nonzero. Required: all outputs are 0 immediately, and there is no event after release while sToggle stays low.
